// File: rtl/aes_pkg.sv
// Shared AES byte-state constants and the ShiftRows source-index mapping.
// Row-major state order: index k = row*4 + column.
package aes_pkg;

    localparam int STATE_BYTES = 16;
    localparam int ROWS        = 4;
    localparam int COLS        = 4;

    // Source index of output position (row, col); 2-bit column arithmetic wraps mod 4.
    function automatic logic [3:0] sr_src_idx(
        input logic [1:0] row,
        input logic [1:0] col,
        input logic       inv
    );
        logic [1:0] src_col;
        src_col = inv ? (col - row) : (col + row);
        return {row, src_col};
    endfunction

endpackage

// File: rtl/sr_bank.sv
// One 16x8 ping-pong state bank: synchronous write port, combinational indexed read port.
module sr_bank #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DW-1:0]            rdata_o
);

    // Contents are not reset; the full flags in the parent gate visibility.
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/shift_rows_serial.sv
// Byte-serial AES ShiftRows with ping-pong 16-byte banks.
// Optional macro SHIFT_ROWS_SERIAL_INV_EN adds the per-state 'inv' input (inverse ShiftRows).
module shift_rows_serial
    import aes_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef SHIFT_ROWS_SERIAL_INV_EN
    input  logic          inv,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_byte,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_byte,
    output logic          out_last
);

    localparam logic [3:0] LAST_IDX = 4'(STATE_BYTES - 1);

    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [3:0] wr_cnt_q,  wr_cnt_d;
    logic [3:0] rd_cnt_q,  rd_cnt_d;
    logic [1:0] full_q,    full_d;

    logic          wr_fire, rd_fire;
    logic          rd_inv;
    logic [3:0]    rd_idx;
    logic [DW-1:0] bank_rdata [2];

    assign in_ready  = ~full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign wr_fire   = in_valid & in_ready;
    assign rd_fire   = out_valid & out_ready;

    // The read counter walks output positions; the mapping picks the source byte.
    assign rd_idx    = sr_src_idx(rd_cnt_q[3:2], rd_cnt_q[1:0], rd_inv);
    assign out_byte  = out_valid ? bank_rdata[rd_bank_q] : '0;
    assign out_last  = out_valid && (rd_cnt_q == LAST_IDX);

`ifdef SHIFT_ROWS_SERIAL_INV_EN
    logic [1:0] inv_q, inv_d;

    always_comb begin
        inv_d = inv_q;
        if (wr_fire && (wr_cnt_q == 4'd0)) begin
            inv_d[wr_bank_q] = inv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= '0;
        end else begin
            inv_q <= inv_d;
        end
    end

    assign rd_inv = inv_q[rd_bank_q];
`else
    assign rd_inv = 1'b0;
`endif

    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        full_d    = full_q;
        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
            if (wr_cnt_q == LAST_IDX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        // Write only targets a non-full bank and read only a full one, so they never collide.
        if (rd_fire) begin
            rd_cnt_d = rd_cnt_q + 4'd1;
            if (rd_cnt_q == LAST_IDX) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            full_q    <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            full_q    <= full_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        sr_bank #(
            .DW    (DW),
            .DEPTH (STATE_BYTES)
        ) u_bank (
            .clk     (clk),
            .we_i    (wr_fire && (wr_bank_q == 1'(b))),
            .waddr_i (wr_cnt_q),
            .wdata_i (in_byte),
            .raddr_i (rd_idx),
            .rdata_o (bank_rdata[b])
        );
    end

endmodule

// File: doc/shift_rows_serial.md
SHIFT_ROWS_SERIAL -- requirements
Module: shift_rows_serial

Interface
REQ-001 SHALL have parameter DW, default 8, meaning byte-lane width; only the value 8 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  input byte present.
REQ-005 SHALL have port in_ready  output  1  block can accept an input byte.
REQ-006 SHALL have port in_byte  input  8  state byte, row-major order s0..s15 (row r = k/4, column c = k%4).
REQ-007 SHALL have port out_valid  output  1  output byte present.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the output byte.
REQ-009 SHALL have port out_byte  output  8  shifted state byte, same row-major order.
REQ-010 SHALL have port out_last  output  1  asserted with the 16th output byte of a state.

Function
REQ-011 SHALL transfer an input byte only on a cycle with in_valid && in_ready, and an output byte only on a cycle with out_valid && out_ready.
REQ-012 SHALL apply forward ShiftRows: output position (r,c) = input byte (r,(c+r) mod 4), i.e. out row1 = s5 s6 s7 s4, row2 = s10 s11 s8 s9, row3 = s15 s12 s13 s14; row0 unchanged.
REQ-013 SHALL buffer states in two 16-byte banks (ping-pong), with a 4-bit write counter and a 4-bit read counter, each wrapping 15 -> 0.
REQ-014 SHALL mark a bank full on the cycle its 16th byte is written, and mark it empty on the cycle its 16th byte is read.
REQ-015 SHALL drive in_ready = 1 exactly when the current write bank is not full.
REQ-016 SHALL drive out_valid = 1 exactly when the current read bank is full.
REQ-017 SHALL assert out_valid on the cycle after the 16th input byte is accepted (latency 1 cycle from last write to first read).
REQ-018 SHALL sustain 1 byte/cycle continuously with both ends always ready: no gap between consecutive input states and no gap between consecutive output states.
REQ-019 SHALL allow simultaneous write to one bank and read from the other in the same cycle.
REQ-020 SHALL, when the read bank frees on the same cycle the write side is stalled on it, raise in_ready on the next cycle (registered flag).
REQ-021 SHALL hold out_byte and out_last stable while out_valid && !out_ready.
REQ-022 SHALL never present a partially written state; out_valid SHALL stay 0 until all 16 bytes of a state are written.

Reset
REQ-023 SHALL, when rst_n is low, asynchronously clear both counters, both full flags and the bank pointers; in_ready = 1, out_valid = 0, out_last = 0 and out_byte = 8'h00 during and after reset.
REQ-024 SHALL discard any partially received or partially sent state on reset mid-operation; bank data contents need not be reset.

Configuration
REQ-025 SHALL, with macro SHIFT_ROWS_SERIAL_INV_EN defined, add port inv  input  1, sampled on the first byte of each state and stored per bank; inv = 1 applies inverse ShiftRows (r,(c-r) mod 4) to that state.
REQ-026 SHALL, without SHIFT_ROWS_SERIAL_INV_EN, have no inv port and perform forward ShiftRows only.

Structure
REQ-027 SHALL take STATE_BYTES = 16, ROWS = 4, COLS = 4 and the ShiftRows index-mapping function (row, column, inv) -> source index from the shared aes_pkg package.
REQ-028 SHALL instantiate sub-module sr_bank (16x8 storage with a write port and an indexed read port) twice, once per ping-pong bank.

Verification
REQ-029 SHALL verify: bytes 00..0F with both ends always ready -> out 00 01 02 03 05 06 07 04 0A 0B 08 09 0F 0C 0D 0E, out_last on 0E, and out_valid on the cycle after byte 0F is written.
REQ-030 SHALL verify: three back-to-back states with out_ready held 0 -> in_ready falls after 32 bytes; after out_ready rises, all 48 output bytes arrive in order.
REQ-031 SHALL verify: out_ready toggling randomly over states 10..1F and 20..2F -> output bytes stable during stalls and no byte lost or duplicated.
REQ-032 SHALL verify: rst_n pulsed low after 7 input bytes -> out_valid = 0 and in_ready = 1; the next 16 bytes form a clean first state.
REQ-033 SHALL verify: with SHIFT_ROWS_SERIAL_INV_EN defined, inv = 1 on bytes 00..0F -> 00 01 02 03 07 04 05 06 0A 0B 08 09 0D 0E 0F 0C; the following state with inv = 0 yields the forward order.
